// File: rtl/alu_ctrl_if.sv
// rtl/alu_ctrl_if.sv - command, ALU drive/response and result signals of alu_ctrl
// o_err_cnt exists only when ALU_CTRL_ERRCNT_EN is defined.
interface alu_ctrl_if #(
   parameter int BITS = 8
);
   logic            i_cmd_valid;
   logic            o_cmd_ready;
   logic [BITS-1:0] i_cmd_a;
   logic [BITS-1:0] i_cmd_b;
   logic [1:0]      i_cmd_op;

   logic [BITS-1:0] o_alu_a;
   logic [BITS-1:0] o_alu_b;
   logic [1:0]      o_alu_op;
   logic [BITS-1:0] i_alu_out;
   logic            i_alu_ovf;
   logic            i_alu_err;
   logic            i_alu_even;
   logic            i_alu_single;

   logic            o_res_valid;
   logic            i_res_ready;
   logic [BITS-1:0] o_res_out;
   logic [3:0]      o_res_flags;
   logic            o_busy;
`ifdef ALU_CTRL_ERRCNT_EN
   logic [7:0]      o_err_cnt;
`endif

   modport slave (
      input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
      output o_cmd_ready,
      output o_alu_a, o_alu_b, o_alu_op,
      input  i_alu_out, i_alu_ovf, i_alu_err, i_alu_even, i_alu_single,
      output o_res_valid, o_res_out, o_res_flags,
      input  i_res_ready,
      output o_busy
`ifdef ALU_CTRL_ERRCNT_EN
      , output o_err_cnt
`endif
   );

   modport master (
      output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
      input  o_cmd_ready,
      input  o_alu_a, o_alu_b, o_alu_op,
      output i_alu_out, i_alu_ovf, i_alu_err, i_alu_even, i_alu_single,
      input  o_res_valid, o_res_out, o_res_flags,
      output i_res_ready,
      input  o_busy
`ifdef ALU_CTRL_ERRCNT_EN
      , input o_err_cnt
`endif
   );
endinterface

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - command FIFO feeding an external combinational ALU, one result held until taken
// Optional saturating error counter enabled by ALU_CTRL_ERRCNT_EN.
module alu_ctrl #(
   parameter int BITS  = 8,
   parameter int DEPTH = 4
) (
   input  logic      i_clk,
   input  logic      i_rst,
   alu_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = 2 * BITS + 2;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, empty, push, pop, capture, release_res;
   logic [BITS-1:0] alu_a_q, alu_b_q, res_out_q;
   logic [1:0]      alu_op_q;
   logic [3:0]      res_flags_q;
   logic            res_valid_q;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign push  = bus.i_cmd_valid && !full;

   // Command storage carries no reset; only pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= {bus.i_cmd_op, bus.i_cmd_b, bus.i_cmd_a};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = ISSUE;
         ISSUE:   state_d = HOLD;
         HOLD:    if (bus.i_res_ready) state_d = empty ? IDLE : ISSUE;
         default: state_d = IDLE;
      endcase
   end

   // A handshake in HOLD may pop the next command on the same edge.
   always_comb begin
      pop         = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      case (state_q)
         IDLE:  pop = !empty;
         ISSUE: capture = 1'b1;
         HOLD: begin
            release_res = bus.i_res_ready;
            pop         = bus.i_res_ready && !empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         res_out_q   <= '0;
         res_flags_q <= '0;
         res_valid_q <= 1'b0;
      end else begin
         if (pop)
            {alu_op_q, alu_b_q, alu_a_q} <= mem[rd_ptr];
         if (capture) begin
            res_out_q   <= bus.i_alu_out;
            res_flags_q <= {bus.i_alu_err, bus.i_alu_ovf, bus.i_alu_even, bus.i_alu_single};
            res_valid_q <= 1'b1;
         end else if (release_res) begin
            res_valid_q <= 1'b0;
         end
      end
   end

   assign bus.o_cmd_ready = !full;
   assign bus.o_alu_a     = alu_a_q;
   assign bus.o_alu_b     = alu_b_q;
   assign bus.o_alu_op    = alu_op_q;
   assign bus.o_res_out   = res_out_q;
   assign bus.o_res_flags = res_flags_q;
   assign bus.o_res_valid = res_valid_q;
   assign bus.o_busy      = (state_q != IDLE) || !empty;

`ifdef ALU_CTRL_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         err_cnt_q <= '0;
      else if (capture && bus.i_alu_err && err_cnt_q != 8'hFF)
         err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign bus.o_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - randomized self-checking bench for alu_ctrl with a queue reference model
// Error-count checks are compiled in when ALU_CTRL_ERRCNT_EN is defined.
module tb_alu_ctrl;
   localparam int BITS  = 8;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] b;
      logic [7:0] a;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_ctrl_if #(.BITS(BITS)) bus ();

   alu_ctrl #(.BITS(BITS), .DEPTH(DEPTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Stub ALU: {out, err, ovf, even, single}; op 00 sub, 01 add, 10 and, 11 xor.
   function automatic logic [11:0] alu_model(cmd_t c);
      logic [8:0] w;
      case (c.op)
         2'b00:   w = {1'b0, c.a} - {1'b0, c.b};
         2'b01:   w = {1'b0, c.a} + {1'b0, c.b};
         2'b10:   w = {1'b0, c.a & c.b};
         default: w = {1'b0, c.a ^ c.b};
      endcase
      return {w[7:0], (c.b == 8'hFF), w[8], ~^w[7:0], w[7]};
   endfunction

   logic [11:0] stub;
   assign stub             = alu_model(cmd_t'({bus.o_alu_op, bus.o_alu_b, bus.o_alu_a}));
   assign bus.i_alu_out    = stub[11:4];
   assign bus.i_alu_err    = stub[3];
   assign bus.i_alu_ovf    = stub[2];
   assign bus.i_alu_even   = stub[1];
   assign bus.i_alu_single = stub[0];

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_acc    = 0;
   int   err_seen = 0;
   cmd_t exp_q[$];
   cmd_t last_done = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_cmd(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      bus.i_cmd_valid = v;
      bus.i_cmd_a     = a;
      bus.i_cmd_b     = b;
      bus.i_cmd_op    = op;
   endtask

   // One clock: score the handshake seen before the edge, then verify held results after it.
   task automatic tick();
      logic        acc, hs, hold;
      logic [7:0]  ro;
      logic [3:0]  rf;
      cmd_t        drv, c;
      logic [11:0] m;
      acc  = bus.i_cmd_valid && bus.o_cmd_ready;
      hs   = bus.o_res_valid && bus.i_res_ready;
      hold = bus.o_res_valid && !bus.i_res_ready;
      ro   = bus.o_res_out;
      rf   = bus.o_res_flags;
      drv  = {bus.o_alu_op, bus.o_alu_b, bus.o_alu_a};
      if (hs) begin
         if (exp_q.size() == 0) begin
            check("unexpected_res", 32'd1, 32'd0);
         end else begin
            c = exp_q.pop_front();
            m = alu_model(c);
            check("res_out", ro, m[11:4]);
            check("res_flags", rf, m[3:0]);
            check("alu_drive", drv, c);
            last_done = c;
            if (m[3]) err_seen++;
         end
      end
      if (acc) begin
         exp_q.push_back(cmd_t'({bus.i_cmd_op, bus.i_cmd_b, bus.i_cmd_a}));
         n_acc++;
      end
      @(posedge clk);
      #1;
      if (hold) begin
         check("hold_valid", bus.o_res_valid, 1);
         check("hold_out", bus.o_res_out, ro);
         check("hold_flags", bus.o_res_flags, rf);
         check("hold_alu", {bus.o_alu_op, bus.o_alu_b, bus.o_alu_a}, drv);
      end
   endtask

   task automatic drain();
      bus.i_cmd_valid = 1'b0;
      bus.i_res_ready = 1'b1;
      for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.o_busy); k++)
         tick();
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", bus.o_busy, 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, bus.o_cmd_ready, 1);
      check({tag, "_valid"}, bus.o_res_valid, 0);
      check({tag, "_out"}, bus.o_res_out, 0);
      check({tag, "_flags"}, bus.o_res_flags, 0);
      check({tag, "_alu"}, {bus.o_alu_op, bus.o_alu_b, bus.o_alu_a}, 0);
      check({tag, "_busy"}, bus.o_busy, 0);
   endtask

   initial begin
      set_cmd(1'b0, 8'd0, 8'd0, 2'b00);
      bus.i_res_ready = 1'b0;
      #12;
      check_reset("rst0");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single command: accepted on the first edge, result two edges later.
      set_cmd(1'b1, 8'd5, 8'd3, 2'b00);
      bus.i_res_ready = 1'b1;
      check("first_ready", bus.o_cmd_ready, 1);
      tick();
      check("first_acc", n_acc, 1);
      bus.i_cmd_valid = 1'b0;
      tick();
      check("lat1_valid", bus.o_res_valid, 0);
      tick();
      check("lat2_valid", bus.o_res_valid, 1);
      check("single_out", bus.o_res_out, 8'h02);
      check("single_flags", bus.o_res_flags, 4'b0000);
      drain();

      // Fill: DEPTH queued plus one held, further commands dropped.
      bus.i_res_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         set_cmd(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
         tick();
      end
      check("fill_acc", n_acc, DEPTH + 1);
      check("fill_ready", bus.o_cmd_ready, 0);
      check("fill_busy", bus.o_busy, 1);
      drain();

      // Random traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         set_cmd(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 2'($urandom));
         bus.i_res_ready = 1'($urandom_range(0, 1));
         tick();
      end
      drain();
      check("idle_alu_hold0", {bus.o_alu_op, bus.o_alu_b, bus.o_alu_a}, last_done);
      tick();
      tick();
      check("idle_alu_hold1", {bus.o_alu_op, bus.o_alu_b, bus.o_alu_a}, last_done);

      // Push and pop on one edge with two queued.
      bus.i_res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_cmd(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
         tick();
      end
      bus.i_cmd_valid = 1'b0;
      check("pp_hold", bus.o_res_valid, 1);
      set_cmd(1'b1, 8'hA5, 8'h3C, 2'b01);
      bus.i_res_ready = 1'b1;
      tick();
      bus.i_cmd_valid = 1'b0;
      bus.i_res_ready = 1'b0;
      tick();
      n_acc = 0;
      for (int i = 0; i < 4; i++) begin
         set_cmd(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
         tick();
      end
      check("pp_count", n_acc, DEPTH - 2);
      drain();

      // Reset during ISSUE with three commands queued.
      bus.i_res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_cmd(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
         tick();
      end
      bus.i_cmd_valid = 1'b0;
      bus.i_res_ready = 1'b1;
      tick();
      bus.i_res_ready = 1'b0;
      check("midop_busy", bus.o_busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check_reset("rst_async");
      exp_q.delete();
      err_seen  = 0;
      last_done = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_valid", bus.o_res_valid, 0);
      end
      check("post_rst_busy", bus.o_busy, 0);

`ifdef ALU_CTRL_ERRCNT_EN
      check("errcnt_rst", bus.o_err_cnt, 0);
      for (int i = 0; i < 5; i++) begin
         set_cmd(1'b1, 8'($urandom), (i % 2 == 0) ? 8'hFF : 8'h10, 2'($urandom));
         tick();
         bus.i_cmd_valid = 1'b0;
         tick();
         tick();
      end
      drain();
      check("errcnt3", bus.o_err_cnt, 3);
      n_acc = 0;
      set_cmd(1'b1, 8'h01, 8'hFF, 2'b10);
      for (int k = 0; k < 2000 && n_acc < 300; k++)
         tick();
      check("errcnt_feed", n_acc, 300);
      drain();
      check("errcnt_sat", bus.o_err_cnt, 255);
      check("errcnt_model", err_seen, 303);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
